bit_serial_adder: RTL and testbench

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

---
 rtl/bit_serial_adder_pkg.sv | 13 +
 rtl/bit_serial_adder_if.sv | 28 ++
 rtl/bit_serial_adder_full_add_bit.sv | 14 +
 rtl/bit_serial_adder.sv | 94 +++++++++
 tb/tb_bit_serial_adder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared types for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package bit_serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bit_serial_adder_if.sv
// Handshake/data bundle for the bit-serial adder.
// master: start, a, b, cin out; busy, done, sum, cout in. slave: mirror.
interface bit_serial_adder_if
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/bit_serial_adder_full_add_bit.sv
// One-bit combinational full adder used by the serial datapath.
// Ports: x, y, ci in; s (sum bit), co (carry out) out.
module full_add_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (y & ci) | (ci & x);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one bit per cycle, WIDTH cycles per add.
// Ports: clk, rst_n (async, active-low); bus (slave) carries start/a/b/cin
// in and busy/done/sum/cout out.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    bit_serial_adder_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_bit;
    logic             accept;
    logic             last;

    full_add_bit u_fa (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .ci (carry),
        .s  (s_bit),
        .co (c_bit)
    );

    // Starts arriving mid-RUN are dropped here.
    assign accept = bus.start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN:  if (last)      state_nxt = DONE;
            DONE: state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            s_sr  <= {s_bit, s_sr[WIDTH-1:1]};
            carry <= c_bit;
            cnt   <= cnt + CW'(1);
            // Publish the result only on the final bit so the ports
            // never show a partially shifted sum.
            if (last) begin
                sum_q  <= {s_bit, s_sr[WIDTH-1:1]};
                cout_q <= c_bit;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and randomised checks for bit_serial_adder at WIDTH=8.
// Drives the bus interface and compares against hand/model values.
module tb_bit_serial_adder;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [W-1:0] last_sum;
    logic         last_cout;

    bit_serial_adder_if #(.WIDTH(W)) bus ();

    bit_serial_adder #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation from IDLE; expected values are x+y+c.
    task automatic run_op(input logic [W-1:0] x,
                          input logic [W-1:0] y,
                          input logic c,
                          input bit scramble);
        logic [W:0] exp;
        int lat;
        bit moved;
        exp = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        bus.a = x;
        bus.b = y;
        bus.cin = c;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 0;
        moved = 0;
        while (!bus.done && lat < 40) begin
            if (scramble) begin
                bus.a = W'($urandom);
                bus.b = W'($urandom);
                bus.cin = 1'($urandom);
            end
            if (bus.sum !== last_sum || bus.cout !== last_cout)
                moved = 1;
            tick();
            lat++;
        end
        check("latency", lat, W);
        check("sum", bus.sum, exp[W-1:0]);
        check("cout", bus.cout, exp[W]);
        check("hold_in_run", moved, 0);
        last_sum = exp[W-1:0];
        last_cout = exp[W];
        tick();
        check("done_pulse", bus.done, 0);
    endtask

    initial begin
        int ndone;
        int last_cyc;
        int bad_busy;
        logic [W-1:0] seen;

        n_checks = 0;
        n_errors = 0;
        last_sum = '0;
        last_cout = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.cout, 0);
        rst_n = 1'b1;
        tick();

        run_op(8'h5A, 8'h3C, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 0);
        repeat (3) tick();
        check("idle_hold_sum", bus.sum, 8'hFF);
        check("idle_hold_cout", bus.cout, 1);

        // Start during RUN must be ignored.
        bus.a = 8'h12;
        bus.b = 8'h34;
        bus.cin = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        bus.a = 8'h11;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        ndone = 0;
        seen = '0;
        for (int i = 0; i < 15; i++) begin
            if (bus.done) begin
                ndone++;
                seen = bus.sum;
            end
            tick();
        end
        check("ignore_ndone", ndone, 1);
        check("ignore_sum", seen, 8'h46);

        // Start held high: back-to-back with period W+1.
        bus.a = 8'h0F;
        bus.b = 8'h01;
        bus.cin = 1'b0;
        bus.start = 1'b1;
        ndone = 0;
        last_cyc = 0;
        bad_busy = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus.busy === bus.done) bad_busy++;
            if (bus.done) begin
                ndone++;
                check("b2b_sum", bus.sum, 8'h10);
                if (ndone > 1) check("b2b_period", i - last_cyc, W + 1);
                last_cyc = i;
            end
        end
        check("b2b_ndone", ndone, 3);
        check("b2b_busy", bad_busy, 0);
        bus.start = 1'b0;
        repeat (12) tick();
        last_sum = 8'h10;
        last_cout = 1'b0;

        // Reset 4 cycles into RUN aborts without a done pulse.
        bus.a = 8'h80;
        bus.b = 8'h80;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_sum", bus.sum, 0);
        check("abort_cout", bus.cout, 0);
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) ndone++;
            tick();
        end
        check("abort_nodone", ndone, 0);
        last_sum = '0;
        last_cout = 1'b0;
        run_op(8'h01, 8'h01, 1'b0, 0);

        for (int i = 0; i < 1000; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
